video_timing_ctrl: RTL and testbench
====================================

// Module: video_timing_ctrl
// PURPOSE
//  Raster sequencer for the DVI transmitter: generates hsync/vsync/dena in the pxlclk domain.
//  Issues a pixel request with x/y coordinates one cycle ahead of dena, so a registered colour
//  source lands on the dvi block's r/g/b in step with dena. Supports start/stop on frame boundaries.
//  Sits between the pixel-clock divider/global buffer and the dvi encoder instance.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line
//  H_FP     16   horizontal front porch, pixels
//  H_SYNC   96   hsync pulse width, pixels
//  H_BP     48   horizontal back porch, pixels (H_TOTAL = 800)
//  V_ACTIVE 480  visible lines per frame
//  V_FP     10   vertical front porch, lines
//  V_SYNC   2    vsync pulse width, lines
//  V_BP     33   vertical back porch, lines (V_TOTAL = 525)
//  HS_POL   0    hsync active level (1 = active high)
//  VS_POL   0    vsync active level
//  XW       10   x width; H_TOTAL <= 2**XW is required
//  YW       10   y width; V_TOTAL <= 2**YW is required
// PORTS
//  pxlclk       in   1    pixel clock; the only clock
//  rstn         in   1    asynchronous active-low reset
//  en           in   1    run request; level-sensitive
//  px_req       out  1    pixel request; x/y valid this cycle
//  x            out  XW   column of the requested pixel, 0..H_ACTIVE-1
//  y            out  YW   row of the requested pixel, 0..V_ACTIVE-1
//  frame_start  out  1    1-cycle pulse with px_req at (0,0)
//  line_start   out  1    1-cycle pulse with px_req at x=0 of every active line
//  hsync        out  1    to dvi.hsync, polarity HS_POL
//  vsync        out  1    to dvi.vsync, polarity VS_POL
//  dena         out  1    to dvi.dena
//  busy         out  1    1 while not IDLE
//  frame_cnt    out  16   completed frames; wraps at 2**16
// BEHAVIOUR
//  - Reset (async assert, output regs cleared immediately):
//    state=IDLE, counters=0, px_req/frame_start/line_start/dena/busy=0, x=y=0, frame_cnt=0,
//    hsync=~HS_POL, vsync=~VS_POL.
//  - Position (h,v): h 0..H_TOTAL-1 advances every RUN/DRAIN cycle; v increments when h wraps.
//  - Horizontal region order: ACTIVE [0,H_ACTIVE) -> FP -> SYNC -> BP.
//  - Vertical region order: ACTIVE [0,V_ACTIVE) -> FP -> SYNC -> BP.
//  - Stage 0 (registered from (h,v)): px_req, x=h, y=v, frame_start, line_start.
//  - Stage 1 (registered from stage 0): dena = previous px_req.
//  - hsync/vsync are delayed by the same 2 cycles as dena, so all three stay mutually aligned.
//  - px_req rises exactly 1 cycle before dena, every pixel. x/y hold their last value when px_req=0.
//  - Sync asserted when h (resp. v) is inside its SYNC region. vsync changes only at an h-wrap.
//  - FSM:
//    IDLE  -> RUN    : en=1 sampled; h=v=0 on the next edge.
//    RUN   -> DRAIN  : en=0 sampled.
//    DRAIN -> RUN    : en=1 before frame end; no discontinuity in timing.
//    DRAIN -> IDLE   : at the last pixel of line V_TOTAL-1. Pipeline flushes 2 cycles later; then
//                      outputs are inactive and busy=0.
//    RUN at frame end: frame_cnt+1, (h,v) -> (0,0).
//  - Timing from IDLE: en high sampled at edge k -> px_req=1, x=y=0, frame_start=1 after edge k+1;
//    dena=1 after edge k+2.
//  - Simultaneous en drop and frame end: go to IDLE directly and increment frame_cnt.
//  - Reset mid-frame: abort immediately; no partial-frame count.
//  - Counters never exceed TOTAL-1 (compare == TOTAL-1, no overflow wrap).
// STRUCTURE
//  - Package video_timing_pkg:
//    * 640x480@60 constants (defaults above)
//    * FSM state encoding IDLE/RUN/DRAIN
//    * region encoding ACTIVE/FP/SYNC/BP
//  - Sub-module video_axis_cnt (params ACTIVE/FP/SYNC/BP/W):
//    * ports: inc in, clr in, cnt out, region out, wrap out (combinational, at cnt==TOTAL-1)
//    * instantiated twice; the vertical instance has inc = horizontal wrap.
//  - Top: FSM, stage-0/stage-1 registers, frame_cnt.
// TESTING
//  1. Reset, en=1 -> px_req at edge 1 (x=0,y=0,frame_start=1), dena at edge 2.
//     Per line: 640 px_req cycles; 800 cycles between line_start pulses.
//  2. Free-run 2 frames -> each frame 420000 cycles. hsync low 96 cycles starting 656 cycles after
//     dena rise. vsync low for lines 490-491 (2*800 cycles). frame_cnt=2.
//  3. Drop en at line 100 -> timing continues to end of frame, then busy=0 and outputs idle.
//     frame_cnt=1; no dena afterwards.
//  4. Drop en at line 100, raise at line 300 -> no gap; the next frame_start falls exactly 420000
//     cycles after the previous one.
//  5. Assert rstn=0 mid-active line 200 -> all outputs reset values with no clock edge required.
//     Re-enable restarts at (0,0).
//  6. Params H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1 -> 14x7=98-cycle frame, active-high syncs.
//     Check every boundary cycle against a reference model.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants and encodings for the raster sequencer.
// The defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package video_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10
  } vt_state_e;

  typedef enum logic [1:0] {
    RegActive = 2'b00,
    RegFp     = 2'b01,
    RegSync   = 2'b10,
    RegBp     = 2'b11
  } vt_region_e;

endpackage

// File: rtl/video_axis_cnt.sv
// One raster axis: position counter with wrap at TOTAL-1 and decoded region.
// Used once per pixel for the horizontal axis and once per line for the vertical axis.
module video_axis_cnt
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output vt_region_e   region,
  output logic         wrap
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START   = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] BP_START   = W'(ACTIVE + FP + SYNC);

  // Exact compare keeps the counter inside 0..TOTAL-1 even when TOTAL < 2**W.
  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    if (cnt < FP_START) begin
      region = RegActive;
    end else if (cnt < SYNC_START) begin
      region = RegFp;
    end else if (cnt < BP_START) begin
      region = RegSync;
    end else begin
      region = RegBp;
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer for the DVI transmitter: hsync/vsync/dena plus a pixel request
// that leads dena by one cycle so a registered colour source lines up with dena.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input  logic          pxlclk,
  input  logic          rstn,
  input  logic          en,
  output logic          px_req,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_start,
  output logic          line_start,
  output logic          hsync,
  output logic          vsync,
  output logic          dena,
  output logic          busy,
  output logic [15:0]   frame_cnt
);

  vt_state_e     state;
  logic          running;
  logic [XW-1:0] h;
  logic [YW-1:0] v;
  vt_region_e    h_region;
  vt_region_e    v_region;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_end;
  logic          px_act;
  logic          hs_s0;
  logic          vs_s0;

  assign running   = (state != StIdle);
  assign frame_end = running & h_wrap & v_wrap;
  assign px_act    = running && (h_region == RegActive) && (v_region == RegActive);

  video_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (XW)
  ) u_h_cnt (
    .clk    (pxlclk),
    .rst_n  (rstn),
    .inc    (running),
    .clr    (!running),
    .cnt    (h),
    .region (h_region),
    .wrap   (h_wrap)
  );

  video_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (YW)
  ) u_v_cnt (
    .clk    (pxlclk),
    .rst_n  (rstn),
    .inc    (running & h_wrap),
    .clr    (!running),
    .cnt    (v),
    .region (v_region),
    .wrap   (v_wrap)
  );

  // A started frame always runs to its end; en is only honoured at the frame boundary
  // (DRAIN just remembers that en has gone low so a re-raise continues seamlessly).
  always_ff @(posedge pxlclk or negedge rstn) begin
    if (!rstn) begin
      state     <= StIdle;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (en) begin
            state <= StRun;
            busy  <= 1'b1;
          end
        end
        StRun, StDrain: begin
          if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
            state     <= en ? StRun : StIdle;
            busy      <= en;
          end else begin
            state <= en ? StRun : StDrain;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 0 carries the request and raw sync flags; stage 1 aligns dena/hsync/vsync.
  always_ff @(posedge pxlclk or negedge rstn) begin
    if (!rstn) begin
      px_req      <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hs_s0       <= 1'b0;
      vs_s0       <= 1'b0;
      dena        <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else begin
      px_req <= px_act;
      if (px_act) begin
        x <= h;
        y <= v;
      end
      frame_start <= px_act && (h == '0) && (v == '0);
      line_start  <= px_act && (h == '0);
      hs_s0       <= running && (h_region == RegSync);
      vs_s0       <= running && (v_region == RegSync);
      dena        <= px_req;
      hsync       <= hs_s0 ? HS_POL : ~HS_POL;
      vsync       <= vs_s0 ? VS_POL : ~VS_POL;
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: a 640x480 instance for the real-size line timing and a tiny
// 14x7 instance checked every cycle against a frame-position reference model.
module tb_video_timing_ctrl;

  localparam int SHA = 8, SHF = 2, SHS = 2, SHB = 2;
  localparam int SVA = 4, SVF = 1, SVS = 1, SVB = 1;
  localparam int HT  = SHA + SHF + SHS + SHB;
  localparam int VT  = SVA + SVF + SVS + SVB;
  localparam int FR  = HT * VT;
  localparam bit SPOL = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a, en_a, rstn_b, en_b;
  logic        px_req_a, frame_start_a, line_start_a, hsync_a, vsync_a, dena_a, busy_a;
  logic [9:0]  x_a, y_a;
  logic [15:0] frame_cnt_a;
  logic        px_req_b, frame_start_b, line_start_b, hsync_b, vsync_b, dena_b, busy_b;
  logic [3:0]  x_b;
  logic [2:0]  y_b;
  logic [15:0] frame_cnt_b;

  int tests = 0;
  int fails = 0;

  video_timing_ctrl u_big (
    .pxlclk(clk), .rstn(rstn_a), .en(en_a), .px_req(px_req_a), .x(x_a), .y(y_a),
    .frame_start(frame_start_a), .line_start(line_start_a), .hsync(hsync_a),
    .vsync(vsync_a), .dena(dena_a), .busy(busy_a), .frame_cnt(frame_cnt_a)
  );

  video_timing_ctrl #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(SPOL), .VS_POL(SPOL), .XW(4), .YW(3)
  ) u_small (
    .pxlclk(clk), .rstn(rstn_b), .en(en_b), .px_req(px_req_b), .x(x_b), .y(y_b),
    .frame_start(frame_start_b), .line_start(line_start_b), .hsync(hsync_b),
    .vsync(vsync_b), .dena(dena_b), .busy(busy_b), .frame_cnt(frame_cnt_b)
  );

  // Reference model: a live frame is a linear position p in 0..FR-1 that always runs to its
  // end; en only matters while idle or on the last cycle of a frame.
  bit         m_live;
  int         m_p;
  int         m_frames;
  logic       e_req, e_fs, e_ls, e_hsr, e_vsr, e_dena, e_hs, e_vs, e_busy;
  logic [3:0] e_x;
  logic [2:0] e_y;

  task automatic model_reset();
    m_live = 0; m_p = 0; m_frames = 0;
    e_req = 0; e_fs = 0; e_ls = 0; e_hsr = 0; e_vsr = 0; e_x = '0; e_y = '0;
    e_dena = 0; e_hs = ~SPOL; e_vs = ~SPOL; e_busy = 0;
  endtask

  task automatic model_edge(input logic e);
    int  h, v;
    bit  act;
    h = m_p % HT;
    v = m_p / HT;
    e_dena = e_req;
    e_hs   = e_hsr ? SPOL : ~SPOL;
    e_vs   = e_vsr ? SPOL : ~SPOL;
    act    = m_live && (h < SHA) && (v < SVA);
    e_req  = act;
    if (act) begin
      e_x = 4'(h);
      e_y = 3'(v);
    end
    e_fs  = act && (m_p == 0);
    e_ls  = act && (h == 0);
    e_hsr = m_live && (h >= SHA + SHF) && (h < SHA + SHF + SHS);
    e_vsr = m_live && (v >= SVA + SVF) && (v < SVA + SVF + SVS);
    if (!m_live) begin
      if (e) begin
        m_live = 1;
        m_p    = 0;
      end
    end else if (m_p == FR - 1) begin
      m_frames++;
      m_p    = 0;
      m_live = e;
    end else begin
      m_p++;
    end
    e_busy = m_live;
  endtask

  function automatic logic [29:0] obs_b();
    return {px_req_b, x_b, y_b, frame_start_b, line_start_b, hsync_b, vsync_b, dena_b,
            busy_b, frame_cnt_b};
  endfunction

  function automatic logic [29:0] exp_b();
    return {e_req, e_x, e_y, e_fs, e_ls, e_hs, e_vs, e_dena, e_busy, 16'(m_frames)};
  endfunction

  task automatic step_b(input logic e);
    en_b = e;
    @(posedge clk);
    model_edge(e);
    #1;
  endtask

  task automatic test_reset();
    rstn_a = 0; rstn_b = 0; en_a = 0; en_b = 0;
    model_reset();
    #12;
    tests++;
    if ({px_req_a, x_a, y_a, frame_start_a, line_start_a, hsync_a, vsync_a, dena_a, busy_a,
         frame_cnt_a} !== {1'b0, 20'd0, 2'b00, 2'b11, 2'b00, 16'd0}) begin
      fails++;
      $display("FAIL reset_big got=%b/%b/%b/%h", px_req_a, hsync_a, vsync_a, frame_cnt_a);
    end
    tests++;
    if (obs_b() !== exp_b()) begin
      fails++;
      $display("FAIL reset_small got=%h exp=%h", obs_b(), exp_b());
    end
    @(posedge clk); #1;
    rstn_a = 1; rstn_b = 1;
    for (int c = 0; c < 4; c++) begin
      step_b(0);
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++;
        $display("FAIL idle_hold c=%0d got=%h exp=%h", c, obs_b(), exp_b());
      end
    end
  endtask

  task automatic test_startup_big();
    int req_cnt = 0, ls2 = -1, hs_first = -1, hs_len = 0, dena_rise = -1, vs_bad = 0, fs_cnt = 0;
    logic dena_prev = 1'b0;
    en_a = 1;
    @(posedge clk); #1;
    tests++;
    if (px_req_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++;
      $display("FAIL start_edge0 px_req=%b busy=%b exp 0/1", px_req_a, busy_a);
    end
    @(posedge clk); #1;
    tests++;
    if ({px_req_a, x_a, y_a, frame_start_a, line_start_a, dena_a} !==
        {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL start_edge1 req=%b x=%0d y=%0d fs=%b ls=%b dena=%b", px_req_a, x_a, y_a,
               frame_start_a, line_start_a, dena_a);
    end
    for (int c = 0; c < 1000; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (c < 800 && px_req_a) req_cnt++;
      if (c > 0 && line_start_a && ls2 < 0) ls2 = c;
      if (frame_start_a) fs_cnt++;
      if (dena_a && !dena_prev && dena_rise < 0) dena_rise = c;
      dena_prev = dena_a;
      if (c < 800 && !hsync_a) begin
        if (hs_first < 0) hs_first = c;
        hs_len++;
      end
      if (vsync_a !== 1'b1) vs_bad++;
    end
    en_a = 0;
    tests++;
    if (dena_rise !== 1) begin fails++; $display("FAIL dena_rise got=%0d exp=1", dena_rise); end
    tests++;
    if (req_cnt !== 640) begin fails++; $display("FAIL px_per_line got=%0d exp=640", req_cnt); end
    tests++;
    if (ls2 !== 800) begin fails++; $display("FAIL line_period got=%0d exp=800", ls2); end
    tests++;
    if (hs_first - dena_rise !== 656) begin
      fails++;
      $display("FAIL hsync_offset got=%0d exp=656", hs_first - dena_rise);
    end
    tests++;
    if (hs_len !== 96) begin fails++; $display("FAIL hsync_width got=%0d exp=96", hs_len); end
    tests++;
    if (vs_bad !== 0) begin fails++; $display("FAIL vsync_early got=%0d exp=0", vs_bad); end
    tests++;
    if (fs_cnt !== 1) begin fails++; $display("FAIL frame_start_cnt got=%0d exp=1", fs_cnt); end
  endtask

  task automatic test_free_run();
    int fs_last = -1, fs_cnt = 0, sp_bad = 0, vs_cnt = 0;
    for (int c = 0; c < 2 * FR + 1; c++) begin
      step_b(1);
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++;
        $display("FAIL free_run c=%0d got=%h exp=%h", c, obs_b(), exp_b());
      end
      if (vsync_b) vs_cnt++;
      if (frame_start_b) begin
        if (fs_last >= 0 && c - fs_last != FR) sp_bad++;
        fs_last = c;
        fs_cnt++;
      end
    end
    tests++;
    if (frame_cnt_b !== 16'd2) begin
      fails++;
      $display("FAIL free_run_frames got=%0d exp=2", frame_cnt_b);
    end
    tests++;
    if (fs_cnt !== 2 || sp_bad !== 0) begin
      fails++;
      $display("FAIL free_run_period starts=%0d bad=%0d exp 2/0", fs_cnt, sp_bad);
    end
    tests++;
    if (vs_cnt !== 2 * HT) begin
      fails++;
      $display("FAIL vsync_width got=%0d exp=%0d", vs_cnt, 2 * HT);
    end
  endtask

  task automatic test_drop_en();
    int stop = 2 * HT + int'($urandom_range(0, HT - 1));
    int idle_for = 0, late_dena = 0;
    for (int c = 0; c < stop; c++) begin
      step_b(1);
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++;
        $display("FAIL drop_run c=%0d got=%h exp=%h", c, obs_b(), exp_b());
      end
    end
    for (int c = 0; c < FR + 40; c++) begin
      step_b(0);
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++;
        $display("FAIL drop_drain c=%0d got=%h exp=%h", c, obs_b(), exp_b());
      end
      if (!busy_b) idle_for++;
      if (idle_for > 2 && dena_b) late_dena++;
    end
    tests++;
    if (busy_b !== 1'b0 || frame_cnt_b !== 16'd3 || late_dena !== 0) begin
      fails++;
      $display("FAIL drop_final busy=%b frames=%0d late=%0d exp 0/3/0", busy_b, frame_cnt_b,
               late_dena);
    end
  endtask

  task automatic test_resume();
    int drop_at = HT + int'($urandom_range(0, HT - 1));
    int rise_at = 3 * HT + int'($urandom_range(0, HT - 1));
    int fs_last = -1, fs_cnt = 0, sp_bad = 0;
    for (int c = 0; c < 3 * FR + 3; c++) begin
      step_b(!(c >= drop_at && c < rise_at));
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++;
        $display("FAIL resume c=%0d got=%h exp=%h", c, obs_b(), exp_b());
      end
      if (frame_start_b) begin
        if (fs_last >= 0 && c - fs_last != FR) sp_bad++;
        fs_last = c;
        fs_cnt++;
      end
    end
    tests++;
    if (fs_cnt !== 4 || sp_bad !== 0 || frame_cnt_b !== 16'd6) begin
      fails++;
      $display("FAIL resume_gap starts=%0d bad=%0d frames=%0d exp 4/0/6", fs_cnt, sp_bad,
               frame_cnt_b);
    end
  endtask

  task automatic test_random();
    int   left = 0;
    logic e = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (left == 0) begin
        e    = 1'($urandom_range(0, 1));
        left = int'($urandom_range(1, 150));
      end
      left--;
      step_b(e);
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++;
        $display("FAIL random c=%0d en=%b got=%h exp=%h", c, e, obs_b(), exp_b());
      end
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!(m_live && m_p == 2 * HT + 3) && n < 4 * FR) begin
      step_b(1);
      n++;
    end
    tests++;
    if (n >= 4 * FR) begin
      fails++;
      $display("FAIL mid_reset_reach steps=%0d exp<%0d", n, 4 * FR);
    end
    #3;
    rstn_b = 0;
    #1;
    model_reset();
    tests++;
    if (obs_b() !== exp_b()) begin
      fails++;
      $display("FAIL async_reset got=%h exp=%h", obs_b(), exp_b());
    end
    @(posedge clk); @(posedge clk); #1;
    tests++;
    if (obs_b() !== exp_b()) begin
      fails++;
      $display("FAIL reset_hold got=%h exp=%h", obs_b(), exp_b());
    end
    rstn_b = 1;
    for (int c = 0; c < 120; c++) begin
      step_b(1);
      tests++;
      if (obs_b() !== exp_b()) begin
        fails++;
        $display("FAIL restart c=%0d got=%h exp=%h", c, obs_b(), exp_b());
      end
      if (c == 1) begin
        tests++;
        if ({px_req_b, x_b, y_b, frame_start_b} !== {1'b1, 4'd0, 3'd0, 1'b1}) begin
          fails++;
          $display("FAIL restart_origin req=%b x=%0d y=%0d fs=%b exp 1/0/0/1", px_req_b, x_b,
                   y_b, frame_start_b);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup_big();
    test_free_run();
    test_drop_en();
    test_resume();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
